// File: rtl/seq_match_fsm_if.sv
// Serial pattern-detector port bundle: stream, mode and pattern-load controls in,
// match pulse and match count out.
interface seq_match_fsm_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_value;
  logic             out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in, overlap, pat_load, pat_value,
    input  out, match_count
  );

  modport slave (
    input  in_valid, in, overlap, pat_load, pat_value,
    output out, match_count
  );
endinterface

// File: rtl/seq_match_fsm.sv
// Run-time-loadable serial pattern detector with overlapping/non-overlapping match modes.
// Optional saturating match counter is built only when SEQ_MATCH_CNT_EN is defined.
module seq_match_fsm #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101),
  parameter int               CNT_W   = 8
) (
  input  logic         clk,
  input  logic         areset,
  seq_match_fsm_if.slave bus
);

  localparam int                FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

  typedef enum logic {FILL, ARMED} state_t;

  logic [PAT_W-1:0]  pat_q,  pat_n;
  logic [PAT_W-1:0]  hist_q, hist_n;
  logic [FILL_W-1:0] fill_q, fill_n;
  logic              out_q,  out_n;

  state_t            state;
  logic [PAT_W-1:0]  hist_acc;
  logic [FILL_W-1:0] fill_acc;
  logic              match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (areset) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_n;
      hist_q <= hist_n;
      fill_q <= fill_n;
      out_q  <= out_n;
    end
  end

  // Next state: candidate history/fill assume the bit is accepted
  always_comb begin
    state    = (fill_q == FULL) ? ARMED : FILL;
    hist_acc = {hist_q[PAT_W-2:0], bus.in};
    fill_acc = (state == ARMED) ? FULL : fill_q + 1'b1;
    match    = (fill_acc == FULL) && (hist_acc == pat_q);

    pat_n  = pat_q;
    hist_n = hist_q;
    fill_n = fill_q;
    out_n  = 1'b0;

    if (bus.pat_load) begin
      pat_n  = bus.pat_value;
      hist_n = '0;
      fill_n = '0;
    end else if (bus.in_valid) begin
      if (match) begin
        out_n = 1'b1;
        // Non-overlapping mode restarts collection from scratch after a hit
        if (bus.overlap) begin
          hist_n = hist_acc;
          fill_n = FULL;
        end else begin
          hist_n = '0;
          fill_n = '0;
        end
      end else begin
        hist_n = hist_acc;
        fill_n = fill_acc;
      end
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (areset || bus.pat_load) begin
      cnt_q <= '0;
    end else if (out_q) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  // Outputs
  always_comb begin
    bus.out         = out_q;
    bus.match_count = cnt_q;
  end
`else
  // Outputs
  always_comb begin
    bus.out         = out_q;
    bus.match_count = '0;
  end
`endif

endmodule

// File: tb/tb_seq_match_fsm.sv
// Scoreboard bench for seq_match_fsm: default instance plus a CNT_W=2 instance for saturation.
module tb_seq_match_fsm;

`ifdef SEQ_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       tb_valid = 1'b0;
  logic       tb_in = 1'b0;
  logic       tb_ovl = 1'b0;
  logic       tb_load = 1'b0;
  logic [2:0] tb_pv = 3'b000;

  int nchk = 0;
  int nerr = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_match_fsm_if #(.PAT_W(3), .CNT_W(8)) bus  ();
  seq_match_fsm_if #(.PAT_W(3), .CNT_W(2)) bus2 ();

  assign bus.in_valid   = tb_valid;
  assign bus.in         = tb_in;
  assign bus.overlap    = tb_ovl;
  assign bus.pat_load   = tb_load;
  assign bus.pat_value  = tb_pv;
  assign bus2.in_valid  = tb_valid;
  assign bus2.in        = tb_in;
  assign bus2.overlap   = tb_ovl;
  assign bus2.pat_load  = tb_load;
  assign bus2.pat_value = tb_pv;

  seq_match_fsm #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(8)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  seq_match_fsm #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(2)) dut_c2 (
    .clk    (clk),
    .areset (areset),
    .bus    (bus2)
  );

  // Drive one cycle of stimulus, queue the out value expected after this edge
  task automatic drive(input logic v, input logic b, input logic ld,
                       input logic [2:0] pv, input logic e);
    tb_valid = v;
    tb_in    = b;
    tb_load  = ld;
    tb_pv    = pv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    logic e;
    areset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    areset = 1'b0;
    repeat (2) begin
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL reset_out got=%b exp=%b", bus.out, e);
      end
    end
    nchk++;
    if (bus.match_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset_count got=%0d exp=0", bus.match_count);
    end
  endtask

  task automatic test_stream(input logic ovl, input logic [4:0] exp_bits, input int exp_cnt,
                             input string name);
    logic [4:0] bits;
    logic e;
    bits = 5'b10101;
    apply_reset();
    e = exp_q.pop_front();
    nchk++;
    if (bus.out !== e || bus.match_count !== 8'd0) begin
      nerr++;
      $display("FAIL %s_reset out=%b cnt=%0d exp out=%b cnt=0", name, bus.out, bus.match_count, e);
    end
    tb_ovl = ovl;
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 3'b000, exp_bits[i]);
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL %s_out bit%0d got=%b exp=%b", name, 4 - i, bus.out, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    e = exp_q.pop_front();
    nchk++;
    if (bus.out !== e) begin
      nerr++;
      $display("FAIL %s_idle got=%b exp=%b", name, bus.out, e);
    end
    nchk++;
    if (bus.match_count !== 8'(exp_cnt)) begin
      nerr++;
      $display("FAIL %s_count got=%0d exp=%0d", name, bus.match_count, exp_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] vld, bits, expo;
    logic e;
    vld  = 7'b1001001;
    bits = 7'b1110111;  // invalid slots carry 1s that must be ignored
    expo = 7'b0000001;
    apply_reset();
    void'(exp_q.pop_front());
    tb_ovl = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      drive(vld[i], bits[i], 1'b0, 3'b000, expo[i]);
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL gaps_out slot%0d got=%b exp=%b", 6 - i, bus.out, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    e = exp_q.pop_front();
    nchk++;
    if (bus.out !== e) begin
      nerr++;
      $display("FAIL gaps_idle got=%b exp=%b", bus.out, e);
    end
  endtask

  task automatic test_pat_load();
    logic [2:0] bits, expo;
    logic e;
    nchk++;
    if (bus.match_count !== 8'(CNT_EN ? 1 : 0)) begin
      nerr++;
      $display("FAIL load_precount got=%0d exp=%0d", bus.match_count, CNT_EN ? 1 : 0);
    end
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'b110, 1'b0);  // bit on the load cycle is dropped
    repeat (3) begin
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL load_pre_out got=%b exp=%b", bus.out, e);
      end
    end
    nchk++;
    if (bus.match_count !== 8'd0) begin
      nerr++;
      $display("FAIL load_count_clear got=%0d exp=0", bus.match_count);
    end
    bits = 3'b110;
    expo = 3'b001;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 3'b000, expo[i]);
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL load_out bit%0d got=%b exp=%b", 2 - i, bus.out, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    void'(exp_q.pop_front());
  endtask

  task automatic test_areset_mid();
    logic [3:0] bits, expo;
    logic e;
    tb_ovl = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    apply_reset();
    repeat (3) begin
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL mid_pre_out got=%b exp=%b", bus.out, e);
      end
    end
    nchk++;
    if (bus.match_count !== 8'd0) begin
      nerr++;
      $display("FAIL mid_reset_count got=%0d exp=0", bus.match_count);
    end
    bits = 4'b1101;
    expo = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 3'b000, expo[i]);
      e = exp_q.pop_front();
      nchk++;
      if (bus.out !== e) begin
        nerr++;
        $display("FAIL mid_out bit%0d got=%b exp=%b", 3 - i, bus.out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expo;
    logic e;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    repeat (2) void'(exp_q.pop_front());
    tb_ovl = 1'b1;
    expo = 8'b00111111;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, 1'b1, 1'b0, 3'b000, expo[i]);
      e = exp_q.pop_front();
      nchk++;
      if (bus2.out !== e) begin
        nerr++;
        $display("FAIL b2b_out bit%0d got=%b exp=%b", 7 - i, bus2.out, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    e = exp_q.pop_front();
    nchk++;
    if (bus2.out !== e) begin
      nerr++;
      $display("FAIL b2b_idle got=%b exp=%b", bus2.out, e);
    end
    nchk++;
    if (bus2.match_count !== 2'(CNT_EN ? 3 : 0)) begin
      nerr++;
      $display("FAIL b2b_sat_count got=%0d exp=%0d", bus2.match_count, CNT_EN ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0, 5'b00100, CNT_EN ? 1 : 0, "nonovl");
    test_stream(1'b1, 5'b00101, CNT_EN ? 2 : 0, "ovl");
    test_gaps();
    test_pat_load();
    test_areset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seq_match_fsm.md
# seq_match_fsm

Parametrised serial pattern detector: the next generation of the fixed three-bit "101" Moore detector. It adds a run-time-loadable pattern of PAT_W bits, an input qualifier, and a selectable overlapping or non-overlapping match mode. It sits on a serial bit stream after the deserialiser front end and produces a registered one-cycle match pulse for downstream framing logic.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..16.
- PAT_RST, 3'b101 (zero-extended to PAT_W): pattern value loaded at reset.
- CNT_W, 8: width of the match counter; legal range 1..32.
- clk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies `in`; bit accepted only when high.
- in  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle.
- pat_load  in  1  load strobe for the pattern register.
- pat_value  in  PAT_W  new pattern; bit PAT_W-1 is the earliest bit in time, bit 0 is the latest.
- out  out  1  registered match pulse.
- match_count  out  CNT_W  saturating match count; see Configuration.

## Operation
- **Storage**
  - pattern register `pat` [PAT_W].
  - history shift register `hist` [PAT_W]; on an accepted bit, hist <= {hist[PAT_W-2:0], in}.
  - fill counter `fill`, 0..PAT_W, counting valid history bits.
- **States**
  - FILL: fill < PAT_W.
  - ARMED: fill == PAT_W.
- **Accepted bit** (in_valid=1, pat_load=0, areset=0):
  - Shift into hist and compute the next history.
  - Next fill = min(fill+1, PAT_W).
  - A match occurs when next fill == PAT_W and the next hist == pat.
- **On a match**
  - out <= 1 on the next edge.
  - overlap=1: fill stays at PAT_W (ARMED), so the next accepted bit can complete a new match.
  - overlap=0: fill <= 0 and hist <= 0 (back to FILL), so the next match needs PAT_W fresh bits.
- **No accepted bit** (in_valid=0): hist and fill hold; out <= 0.
- **No match**: out <= 0.
- **pat_load=1**
  - pat <= pat_value, hist <= 0, fill <= 0, out <= 0.
  - in_valid and `in` are ignored that cycle.
  - pat_load takes priority over in_valid.
- **areset=1**
  - Highest priority.
  - pat <= PAT_RST, hist <= 0, fill <= 0, out <= 0, match_count <= 0.
  - Mid-stream reset discards partial progress; nothing is carried over.
- **Mode change**: switching `overlap` mid-stream takes effect on the next match only. State is not flushed.

## Timing
- Reset values: out = 0, match_count = 0.
- Latency: out rises exactly one cycle after the edge that accepts the final pattern bit (Moore-style registered output).
- out is a pulse: high for exactly one cycle per match, never held.
- Back-to-back pulses on consecutive cycles are legal in overlap mode (e.g. pattern 2'b11, input 1,1,1).
- No handshake back-pressure: every in_valid=1 bit is consumed in its cycle.
- First possible match is PAT_W accepted bits after reset or pat_load.

## Configuration
- Macro: `SEQ_MATCH_CNT_EN`.
- **Defined**
  - match_count increments by 1 on each cycle out is high.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared by areset and by pat_load.
- **Undefined**
  - The counter logic is not built.
  - match_count is tied to 0.
  - The port remains present, so the interface is identical in both builds.

## Test plan
- Reset, then PAT_W=3 default pattern, overlap=0, stream 1,0,1,0,1 all valid -> one out pulse, one cycle after the third bit; no pulse after the fifth bit.
- Same stream with overlap=1 -> pulses after the 3rd and 5th bits; match_count=2 with SEQ_MATCH_CNT_EN, 0 without.
- Stream 1,0,1 with in_valid=0 gaps of 2 cycles between bits -> single pulse one cycle after the 3rd valid bit; out stays 0 during the gaps.
- pat_load with pat_value=3'b110 after bits 1,1 of the old pattern, then stream 1,1,0 -> no match from pre-load bits; pulse after the final 0; match_count reset to 0 at the load.
- areset asserted after bits 1,0 of 1,0,1, then feed 1 -> no pulse. Then 1,0,1 -> pulse; out=0 and match_count=0 in the cycle after reset.
- CNT_W=2, overlap=1, pattern 3'b111, feed eight 1s -> six pulses on consecutive cycles; match_count saturates at 3.
